// File: rtl/data_mem_responder.sv
// Wait-stated data-memory target for the core's data port: one access at a time,
// completion signalled by a single-cycle ready pulse carrying read data or an error.
module data_mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_rd_en,
    input  logic              i_wr_en,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_err,
    output logic              o_busy
);

    localparam int         IDX_W   = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rd_q, wr_q;
    logic              ready_q, err_q, busy_q, rd_valid_q;
    logic [DATA_W-1:0] rd_word_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              req;
    logic              in_idle;
    logic [ADDR_W-1:0] eff_addr;
    logic [DATA_W-1:0] eff_wdata;
    logic              eff_rd, eff_wr, eff_err;
    logic              commit, mem_commit;
    logic [IDX_W-1:0]  mem_idx;

    assign req = i_rd_en | i_wr_en;

    // With zero wait states the commit edge is the accept edge, so the live request
    // stands in for the not-yet-latched copy.
    always_comb begin
        in_idle    = (state_q == ST_IDLE);
        eff_addr   = in_idle ? i_addr  : addr_q;
        eff_wdata  = in_idle ? i_wdata : wdata_q;
        eff_rd     = in_idle ? i_rd_en : rd_q;
        eff_wr     = in_idle ? i_wr_en : wr_q;
        eff_err    = (eff_rd && eff_wr) || (eff_addr[1:0] != 2'b00)
                     || ((eff_addr >> 2) >= ADDR_W'(DEPTH));
        commit     = (in_idle && req && (WAIT_CYCLES == 0))
                     || ((state_q == ST_WAIT) && (cnt_q == 4'd1));
        mem_commit = commit && !eff_err && !rst;
        mem_idx    = eff_addr[IDX_W+1:2];
    end

    // NOTE: the RAM array and its read register sit in a reset-free block so they map
    // onto block RAM; the separately reset rd_valid_q gates what reaches o_rdata.
    always_ff @(posedge clk) begin
        if (mem_commit) begin
            if (eff_wr) begin
                mem[mem_idx] <= eff_wdata;
            end
            rd_word_q <= mem[mem_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        addr_q  <= i_addr;
                        wdata_q <= i_wdata;
                        rd_q    <= i_rd_en;
                        wr_q    <= i_wr_en;
                        cnt_q   <= WAIT_LD;
                        busy_q  <= 1'b1;
                        state_q <= (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        cnt_q   <= 4'd0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
            if (commit) begin
                ready_q    <= 1'b1;
                err_q      <= eff_err;
                rd_valid_q <= eff_rd && !eff_err;
            end
        end
    end

    assign o_ready = ready_q;
    assign o_err   = err_q;
    assign o_busy  = busy_q;
    assign o_rdata = rd_valid_q ? rd_word_q : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: three responders with 2, 0 and 3 wait states, checked with
// immediate assertions against hand-computed values.
module tb_data_mem_responder;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0][31:0] addr, wdata, rdata;
    logic [2:0]       rd_en, wr_en, ready, err, busy;
    int               pass_cnt = 0;
    int               total    = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst), .i_addr(addr[0]), .i_wdata(wdata[0]), .i_rd_en(rd_en[0]),
        .i_wr_en(wr_en[0]), .o_ready(ready[0]), .o_rdata(rdata[0]), .o_err(err[0]), .o_busy(busy[0]));
    data_mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .i_addr(addr[1]), .i_wdata(wdata[1]), .i_rd_en(rd_en[1]),
        .i_wr_en(wr_en[1]), .o_ready(ready[1]), .o_rdata(rdata[1]), .o_err(err[1]), .o_busy(busy[1]));
    data_mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .i_addr(addr[2]), .i_wdata(wdata[2]), .i_rd_en(rd_en[2]),
        .i_wr_en(wr_en[2]), .o_ready(ready[2]), .o_rdata(rdata[2]), .o_err(err[2]), .o_busy(busy[2]));

    function automatic int waits(input int k);
        return (k == 0) ? 2 : (k == 1) ? 0 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one request, wait (bounded) for the ready pulse, check latency and result,
    // then spend the DONE->IDLE cycle so the next call can be accepted at once.
    task automatic access(input int k, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err,
                          input string tag);
        int lat;
        addr[k] = a; wdata[k] = d; rd_en[k] = rd; wr_en[k] = wr;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ready[k] && lat < 20);
        rd_en[k] = 1'b0; wr_en[k] = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(waits(k) + 1));
        check({tag, " rdata"}, rdata[k], exp_rd);
        check({tag, " err"}, 32'(err[k]), {31'd0, exp_err});
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; addr = '0; wdata = '0; rd_en = '0; wr_en = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset ready[%0d]", k), 32'(ready[k]), 32'd0);
            check($sformatf("reset busy[%0d]", k), 32'(busy[k]), 32'd0);
            check($sformatf("reset err[%0d]", k), 32'(err[k]), 32'd0);
            check($sformatf("reset rdata[%0d]", k), rdata[k], 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Write then read with two wait states.
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "w2 wr 0x10");
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "w2 rd 0x10");

        // Zero-wait back-to-back: latency 1 plus the IDLE cycle gives 2-cycle spacing.
        access(1, 1'b0, 1'b1, 32'h0, 32'd1, 32'h0, 1'b0, "w0 wr 0x0");
        access(1, 1'b0, 1'b1, 32'h4, 32'd2, 32'h0, 1'b0, "w0 wr 0x4");
        access(1, 1'b0, 1'b1, 32'h8, 32'd3, 32'h0, 1'b0, "w0 wr 0x8");
        access(1, 1'b1, 1'b0, 32'h0, 32'h0, 32'd1, 1'b0, "w0 rd 0x0");
        access(1, 1'b1, 1'b0, 32'h4, 32'h0, 32'd2, 1'b0, "w0 rd 0x4");
        access(1, 1'b1, 1'b0, 32'h8, 32'h0, 32'd3, 1'b0, "w0 rd 0x8");

        // Error cases; 0x1000 would alias word 0 if the range check were missing.
        access(0, 1'b0, 1'b1, 32'h0, 32'h12345678, 32'h0, 1'b0, "err setup wr 0x0");
        access(0, 1'b1, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1, "err misaligned rd");
        access(0, 1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 32'h0, 1'b1, "err range wr");
        access(0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0, "err range no-update");
        access(0, 1'b1, 1'b1, 32'h0, 32'h00000BAD, 32'h0, 1'b1, "err rd+wr");
        access(0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0, "err rd+wr no-update");

        // Reset during the second WAIT cycle of a three-wait write drops the write.
        access(2, 1'b0, 1'b1, 32'h20, 32'h0, 32'h0, 1'b0, "w3 preinit 0x20");
        addr[2] = 32'h20; wdata[2] = 32'hA5A5A5A5; wr_en[2] = 1'b1;
        @(negedge clk);
        check("w3 busy in wait", 32'(busy[2]), 32'd1);
        @(negedge clk);
        wr_en[2] = 1'b0;
        rst = 1'b1;
        #1;
        check("w3 busy async reset", 32'(busy[2]), 32'd0);
        check("w3 ready async reset", 32'(ready[2]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        access(2, 1'b1, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, "w3 rd after reset");

        // Held read: DONE, one IDLE, re-accept -> ready on every 4th cycle.
        access(0, 1'b0, 1'b1, 32'h4, 32'h44444444, 32'h0, 1'b0, "held setup wr 0x4");
        addr[0] = 32'h4; rd_en[0] = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 16) rd_en[0] = 1'b0;
            check($sformatf("held ready c%0d", i), 32'(ready[0]), ((i % 4) == 3) ? 32'd1 : 32'd0);
            check($sformatf("held busy c%0d", i), 32'(busy[0]), ((i % 4) != 0) ? 32'd1 : 32'd0);
            check($sformatf("held rdata c%0d", i), rdata[0], ((i % 4) == 3) ? 32'h44444444 : 32'h0);
        end
        @(negedge clk);

        // Inputs changed during WAIT must not affect the commit.
        access(0, 1'b0, 1'b1, 32'h34, 32'h11, 32'h0, 1'b0, "wait-ign setup 0x34");
        addr[0] = 32'h30; wdata[0] = 32'h77; wr_en[0] = 1'b1;
        @(negedge clk);
        addr[0] = 32'h34; wdata[0] = 32'h99;
        @(negedge clk);
        @(negedge clk);
        check("wait-ign ready", 32'(ready[0]), 32'd1);
        wr_en[0] = 1'b0;
        @(negedge clk);
        access(0, 1'b1, 1'b0, 32'h30, 32'h0, 32'h77, 1'b0, "wait-ign rd 0x30");
        access(0, 1'b1, 1'b0, 32'h34, 32'h0, 32'h11, 1'b0, "wait-ign rd 0x34");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the RISC-V core's data port, acting as the target side of the core's `o_data_*` / `i_data_ready` / `i_data_rd` handshake. It holds a word-addressed RAM and accepts one read or write at a time. Each access is stretched by a configurable number of wait states, so the core's stall path is exercised. Completion is signalled by a one-cycle ready pulse carrying read data or an error flag. It replaces the zero-wait memory model in the UVM memory testbench and serves as the default data memory in system simulation.

## Interface
- `DATA_W`, 32, data word width.
- `ADDR_W`, 32, byte-address width.
- `DEPTH`, 1024, number of words; must be a power of two.
- `WAIT_CYCLES`, 1, wait states per access; range 0..15.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_addr` in ADDR_W: byte address from the core (`o_data_addr`).
- `i_wdata` in DATA_W: write data (`o_data_wr`).
- `i_rd_en` in 1: read request (`o_data_rd_en_ma`).
- `i_wr_en` in 1: write request (`o_data_wr_en_ma`).
- `o_ready` out 1: completion pulse, drives core `i_data_ready`.
- `o_rdata` out DATA_W: read data, drives core `i_data_rd`.
- `o_err` out 1: error flag, valid only while `o_ready` is 1.
- `o_busy` out 1: high while a request is accepted and not yet completed.

## Operation
- FSM states: IDLE, WAIT, DONE.
- **IDLE:** if `i_rd_en | i_wr_en` is high, latch addr, wdata and op, load wait counter; otherwise stay.
  - Next state is WAIT if WAIT_CYCLES > 0, else DONE.
- **WAIT:** the 4-bit counter decrements each cycle; on reaching zero, go to DONE. Inputs are ignored and only latched values are used.
- **Commit:** happens on the edge entering DONE.
  - Write: RAM[latched_addr[log2(DEPTH)+1:2]] <= latched wdata.
  - Read: `o_rdata` register <= RAM word at the same index.
- **DONE:** `o_ready`=1 for exactly one cycle; next state is always IDLE. The request still visible in DONE is the completed one and is not re-accepted.
- Error conditions, checked on latched values:
  - both rd and wr set;
  - addr[1:0] != 0;
  - word index (addr >> 2) >= DEPTH.
- On error:
  - no RAM update;
  - `o_rdata`=0 and `o_err`=1 in DONE;
  - timing is the same as a normal access.
- `o_rdata` is 0 in every cycle except DONE of a successful read.
- `o_busy` is 1 in WAIT and DONE, 0 in IDLE.
- RAM contents are not reset; reading an unwritten word returns X.

## Timing
- Reset values: state=IDLE, counter=0, `o_ready`=0, `o_rdata`=0, `o_err`=0, `o_busy`=0.
- The request is sampled at edge E0, with the FSM in IDLE.
- Commit occurs at edge E0+WAIT_CYCLES.
- `o_ready` is high during the cycle following that edge.
- Latency from first request cycle to ready cycle: WAIT_CYCLES+1 cycles.
- Throughput: one access per WAIT_CYCLES+2 cycles, with one mandatory IDLE cycle after DONE.
- The initiator holds request signals stable until it samples `o_ready`=1. The responder does not rely on this after E0.
- Read-after-write to the same address in consecutive transactions returns the new data.
- Reset asserted in WAIT: the FSM returns to IDLE, and the pending write is dropped (RAM unchanged), because commit had not occurred. All outputs go to their reset values immediately (asynchronously).
- Reset asserted in DONE: the write is already committed; the ready pulse is truncated.
- A request present when reset deasserts is sampled at the first clock edge after deassertion.

## Test plan
1. **Write then read, WAIT_CYCLES=2:**
   - Stimulus: write 0xDEADBEEF to 0x10, then read 0x10.
   - Required: each `o_ready` pulse occurs 3 cycles after its request cycle; read returns `o_rdata`=0xDEADBEEF with `o_err`=0.
2. **Zero-wait back-to-back, WAIT_CYCLES=0:**
   - Stimulus: writes to 0x0, 0x4, 0x8 (values 1, 2, 3), then reads of the same three addresses.
   - Required: ready pulses are spaced 2 cycles apart; reads return 1, 2, 3.
3. **Error cases:**
   - Read at 0x6 (misaligned) -> `o_err`=1, `o_rdata`=0.
   - Write at 0x1000 with DEPTH=1024 (out of range) -> `o_err`=1, and a later read of 0x0 is unchanged.
   - `i_rd_en` and `i_wr_en` both high -> `o_err`=1, no RAM update.
4. **Reset mid-write, WAIT_CYCLES=3:**
   - Stimulus: write 0xA5A5A5A5 to 0x20; assert `rst` during the second WAIT cycle; release and read 0x20.
   - Required: the old value 0x0 (pre-initialised by the bench) is returned; `o_ready` and `o_busy` drop immediately on reset.
5. **Held request:**
   - Stimulus: keep `i_rd_en` high continuously on 0x4.
   - Required: exactly one IDLE cycle after each DONE, then re-acceptance; `o_ready` pulses once per WAIT_CYCLES+2 cycles with no double pulses.
6. **Inputs ignored during WAIT, WAIT_CYCLES=2:**
   - Stimulus: change `i_addr` and `i_wdata` during WAIT.
   - Required: the commit uses the values latched at E0.
